wrr_lock_arbiter: RTL and testbench
===================================

Name: wrr_lock_arbiter

Overview:
Parametrised next-generation single-cycle arbiter for N requesters, selectable at runtime between fixed-priority, round-robin and weighted round-robin modes. Adds per-requester grant locking for multi-beat transfers. The grant is combinational from the current requests and registered arbitration state, so it is valid in the same cycle as the request. It is a drop-in for shared-resource arbitration points that previously used a plain single-cycle arbiter.

Parameters:
N, 16, number of requesters (N >= 2)
WW, 4, weight field width per requester
IDXW, $clog2(N), grant index width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
mode_i  input  2  arbitration mode (arb_pkg::arb_mode_e), quasi-static
req_i  input  N  request vector, bit k = requester k
lock_i  input  N  bit k high = requester k holds its grant next cycle
weight_i  input  N*WW  weight of requester k at bits [k*WW +: WW]
gnt_o  output  N  one-hot grant or all-zero
gnt_vld_o  output  1  high when any grant is issued (|gnt_o)
gnt_idx_o  output  IDXW  index of the granted requester; 0 when gnt_vld_o is low

Behaviour:
- Reset (reset=0, asynchronous):
  - ptr_q=0, cnt_q=0, lock_vld_q=0, lock_idx_q=0, mode_q=ARB_FIXED.
  - gnt_o, gnt_vld_o and gnt_idx_o are forced to 0 while reset is low.
- Grant invariants every cycle:
  - gnt_o is one-hot or zero, and gnt_o is always a subset of req_i.
  - req_i != 0 (out of reset) implies gnt_vld_o=1.
  - Zero-cycle latency: combinational path from req_i to gnt_o.
- Lock has top priority, in every mode:
  - If lock_vld_q=1 and req_i[lock_idx_q]=1, grant lock_idx_q.
  - If lock_vld_q=1 and req_i[lock_idx_q]=0, the lock is void. Arbitrate normally this cycle and clear the lock at the edge.
- ARB_FIXED: lowest set index of req_i wins; ptr_q and cnt_q are not updated.
- ARB_RR:
  - Search starts at ptr_q and moves upward with wrap (index N-1 wraps to 0).
  - On an unlocked grant to k, ptr_q <= (k+1) mod N.
- ARB_WRR:
  - Search as in RR. The granted requester k keeps the grant for up to weight_i[k]+1 consecutive cycles while req_i[k] stays high.
  - cnt_q counts completed grant cycles for the current owner.
  - When cnt_q == weight_i[k] or req_i[k] drops, ptr_q <= (k+1) mod N and cnt_q <= 0.
  - Otherwise ptr_q is held (so the owner is re-found at ptr_q) and cnt_q increments.
  - Weight 0 behaves exactly as ARB_RR.
- mode_i = 2'b11 (reserved) behaves as ARB_RR.
- Lock update at the clock edge:
  - If gnt_o[k]=1 and lock_i[k]=1: lock_vld_q <= 1, lock_idx_q <= k.
  - If lock_i[gnt_idx] is low, or there is no grant: lock_vld_q <= 0.
  - While locked, ptr_q and cnt_q are frozen.
  - On lock release, ptr advances to (k+1) mod N in RR and WRR modes.
  - lock_i bits of non-granted requesters are ignored.
- Mode change:
  - mode_q registers mode_i. When mode_i != mode_q, cnt_q <= 0 at that edge.
  - ptr_q and the lock are preserved across a mode change.
  - The new mode takes effect combinationally in the same cycle.
- No requests: gnt_o=0 and all state holds, except that a void lock is cleared.
- Reset asserted mid-lock or mid-WRR burst: all state returns to reset values immediately. The first grant after reset comes from requester 0 upward.

Decomposition:
- Package arb_pkg contains:
  - typedef enum logic [1:0] arb_mode_e {ARB_FIXED=2'b00, ARB_RR=2'b01, ARB_WRR=2'b10}
  - localparam ARB_MODE_RSVD=2'b11
  - function onehot2idx
- One sub-module, arb_rot_prio_pick #(N): combinational picker.
  - Inputs: req vector and start pointer.
  - Operation: rotate req by the start pointer, find the first set bit, rotate back.
  - Outputs: one-hot grant and index.
  - FIXED mode drives pointer 0 into the same instance.

Test Plan:
- Bench uses N=4, WW=4.
- Reset and void request: reset=0 with req_i=4'b1111 -> gnt_o=0000, gnt_idx_o=0. After reset=1, FIXED mode with req_i=1010 -> gnt_o=0010 in the same cycle.
- RR fairness and wrap: mode=RR, req_i=1111 held for 6 cycles -> grants 0001, 0010, 0100, 1000, 0001, 0010. Then req_i=0001 with ptr_q=2 -> gnt_o=0001.
- WRR weights: weights {3:0,2:0,1:2,0:1}, req_i=0011 held -> grant sequence 0,0,1,1,1,0,0,1,1,1. Dropping req_i[1] after its first cycle -> the next grant goes to 0.
- Lock: mode=RR, req_i=0110, lock_i[1]=1 for 3 cycles -> gnt_o=0010 for 4 consecutive cycles, then 0100. Dropping req_i[1] while locked -> the same cycle grants 0100 and the lock clears.
- Mode switch mid-WRR: WRR with owner 1 at cnt_q=1, switch to FIXED with req_i=0110 -> gnt_o=0010 and cnt_q=0. Back to RR -> search resumes from the held ptr_q.
- Reset mid-lock: lock held on requester 2, assert reset for 1 cycle then release with req_i=1111 in RR -> gnt_o=0001.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration mode encodings and one-hot helper
package arb_pkg;
  typedef enum logic [1:0] {ARB_FIXED = 2'b00, ARB_RR = 2'b01, ARB_WRR = 2'b10} arb_mode_e;
  localparam logic [1:0] ARB_MODE_RSVD = 2'b11;
  function automatic int onehot2idx(input logic [63:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) r |= oh[i] ? i : 0;
    return r;
  endfunction
endpackage

// File: rtl/arb_rot_prio_pick.sv
// arb_rot_prio_pick: one-hot pick of the first request at or above start, with wrap
module arb_rot_prio_pick import arb_pkg::*; #(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [N-1:0] rot, first;
  logic [IW:0]  sum;
  assign rot   = N'({req, req} >> start);
  assign first = rot & (~rot + 1'b1);
  assign sum   = {1'b0, start} + (IW+1)'(onehot2idx(64'(first)));
  assign idx   = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
  assign gnt   = |req ? N'(1) << idx : '0;
endmodule

// File: rtl/wrr_lock_arbiter.sv
// wrr_lock_arbiter: single-cycle fixed/RR/weighted-RR arbiter with per-requester grant lock
module wrr_lock_arbiter import arb_pkg::*; #(
  parameter int N = 16,
  parameter int WW = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mode_i,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    lock_i,
  input  logic [N*WW-1:0] weight_i,
  output logic [N-1:0]    gnt_o,
  output logic            gnt_vld_o,
  output logic [IDXW-1:0] gnt_idx_o
);
  arb_mode_e       mode_q;
  logic [IDXW-1:0] ptr_q, lock_idx_q, pick_idx, k, nxt_k;
  logic [WW-1:0]   cnt_q, cnt_eff, w_k;
  logic [N-1:0]    pick_gnt;
  logic            lock_vld_q, lock_hit, any, fixed, rr_like, hold, take_lock, adv;
  assign fixed     = mode_i == ARB_FIXED;
  assign rr_like   = mode_i == ARB_RR || mode_i == ARB_MODE_RSVD;
  assign lock_hit  = lock_vld_q && req_i[lock_idx_q];
  assign any       = |req_i;
  assign k         = lock_hit ? lock_idx_q : pick_idx;
  assign nxt_k     = k == IDXW'(N-1) ? '0 : k + 1'b1;
  assign w_k       = weight_i[int'(k)*WW +: WW];
  assign cnt_eff   = k == ptr_q ? cnt_q : '0;
  assign take_lock = any && lock_i[k];
  assign hold      = lock_hit && lock_i[k];
  assign adv       = lock_hit || rr_like || cnt_eff == w_k;
  arb_rot_prio_pick #(.N(N)) u_pick (
    .req   (req_i),
    .start (fixed ? '0 : ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );
  assign gnt_o     = !reset ? '0 : lock_hit ? N'(1) << lock_idx_q : pick_gnt;
  assign gnt_vld_o = reset && any;
  assign gnt_idx_o = gnt_vld_o ? k : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= ARB_FIXED;
      ptr_q      <= '0;
      cnt_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      mode_q     <= arb_mode_e'(mode_i);
      lock_vld_q <= take_lock;
      if (take_lock) lock_idx_q <= k;
      if (any && !fixed && !hold) begin
        ptr_q <= adv ? nxt_k : k;
        cnt_q <= adv ? '0 : cnt_eff + 1'b1;
      end
      if (mode_i != mode_q) cnt_q <= '0;
    end
  end
endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// tb_wrr_lock_arbiter: scoreboard bench for wrr_lock_arbiter with N=4, WW=4
module tb_wrr_lock_arbiter;
  import arb_pkg::*;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode_i;
  logic [3:0]  req_i, lock_i, gnt_o;
  logic [15:0] weight_i;
  logic        gnt_vld_o;
  logic [1:0]  gnt_idx_o;
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp_q[$];
  string       tag_q[$];
  wrr_lock_arbiter #(.N(4), .WW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_i    (mode_i),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .weight_i  (weight_i),
    .gnt_o     (gnt_o),
    .gnt_vld_o (gnt_vld_o),
    .gnt_idx_o (gnt_idx_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction
  task automatic step(input string tag, input logic r, input logic [1:0] m,
                      input logic [3:0] rq, input logic [3:0] lk, input logic [3:0] ex);
    logic [3:0] e;
    string t;
    @(posedge clk);
    #1;
    reset  = r;
    mode_i = m;
    req_i  = rq;
    lock_i = lk;
    exp_q.push_back(ex);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, "_gnt"}, 32'(gnt_o), 32'(e));
    check({t, "_vld"}, 32'(gnt_vld_o), 32'(|e));
    check({t, "_idx"}, 32'(gnt_idx_o), 32'(oh_idx(e)));
  endtask
  initial begin
    logic [3:0] rr_exp[6];
    int         wseq[10];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    wseq   = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    reset    = 1'b0;
    mode_i   = ARB_FIXED;
    req_i    = 4'b0000;
    lock_i   = 4'b0000;
    weight_i = 16'h0021;
    step("rst_void", 1'b0, ARB_FIXED, 4'b1111, 4'b0000, 4'b0000);
    step("fixed", 1'b1, ARB_FIXED, 4'b1010, 4'b0000, 4'b0010);
    for (int i = 0; i < 6; i++) step($sformatf("rr%0d", i), 1'b1, ARB_RR, 4'b1111, 4'b0000, rr_exp[i]);
    step("rr_wrap", 1'b1, ARB_RR, 4'b0001, 4'b0000, 4'b0001);
    step("rr_to3", 1'b1, ARB_RR, 4'b1000, 4'b0000, 4'b1000);
    step("wrr_idle", 1'b1, ARB_WRR, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) step($sformatf("wrr%0d", i), 1'b1, ARB_WRR, 4'b0011, 4'b0000, 4'b0001 << wseq[i]);
    step("wdrop_a", 1'b1, ARB_WRR, 4'b0011, 4'b0000, 4'b0001);
    step("wdrop_b", 1'b1, ARB_WRR, 4'b0011, 4'b0000, 4'b0001);
    step("wdrop_c", 1'b1, ARB_WRR, 4'b0011, 4'b0000, 4'b0010);
    step("wdrop_d", 1'b1, ARB_WRR, 4'b0001, 4'b0000, 4'b0001);
    step("wsw_a", 1'b1, ARB_WRR, 4'b0011, 4'b0000, 4'b0001);
    step("wsw_b", 1'b1, ARB_WRR, 4'b0011, 4'b0000, 4'b0010);
    step("sw_fixed", 1'b1, ARB_FIXED, 4'b0110, 4'b0000, 4'b0010);
    step("sw_rr", 1'b1, ARB_RR, 4'b1101, 4'b0000, 4'b0100);
    for (int i = 0; i < 3; i++) step($sformatf("lock%0d", i), 1'b1, ARB_RR, 4'b0110, 4'b0010, 4'b0010);
    step("lock_last", 1'b1, ARB_RR, 4'b0110, 4'b0000, 4'b0010);
    step("lock_after", 1'b1, ARB_RR, 4'b0110, 4'b0000, 4'b0100);
    step("lvoid_set", 1'b1, ARB_RR, 4'b0110, 4'b0010, 4'b0010);
    step("lvoid_drop", 1'b1, ARB_RR, 4'b0100, 4'b0010, 4'b0100);
    step("lvoid_clr", 1'b1, ARB_RR, 4'b1010, 4'b0000, 4'b1000);
    step("rlock_set", 1'b1, ARB_RR, 4'b0100, 4'b0100, 4'b0100);
    step("rlock_hold", 1'b1, ARB_RR, 4'b1111, 4'b0100, 4'b0100);
    step("rlock_rst", 1'b0, ARB_RR, 4'b1111, 4'b0100, 4'b0000);
    step("rlock_first", 1'b1, ARB_RR, 4'b1111, 4'b0000, 4'b0001);
    step("rsvd_mode", 1'b1, ARB_MODE_RSVD, 4'b1111, 4'b0000, 4'b0010);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
